lcd_rect_fill: RTL and testbench
================================

# lcd_rect_fill

Command sequencer that sits directly upstream of the SPI LCD serializer and drives its load, load16 and in inputs. On a start request it fills a rectangle of the ILI9341-class panel with one RGB565 colour. It issues column-address-set (0x2A), page-address-set (0x2B) and memory-write (0x2C), each with its parameter bytes, then streams one 16-bit pixel word per rectangle pixel. Each transfer is paced by the serializer's busy flag, bit 15 of its out bus.

## Interface
Parameters:
- WIDTH, 240: panel columns; x range is 0..WIDTH-1.
- HEIGHT, 320: panel rows; y range is 0..HEIGHT-1.

Ports:
- clk  in  1  system clock, 25 MHz, shared with the serializer.
- reset  in  1  synchronous, active-high reset.
- start  in  1  single-cycle request; sampled only in IDLE.
- x0, x1  in  9  first and last column, inclusive.
- y0, y1  in  9  first and last row, inclusive.
- color  in  16  RGB565 pixel value.
- busy  out  1  high from the accepted start until the done/err cycle.
- done  out  1  one-cycle pulse when the last pixel has been serialized.
- err  out  1  one-cycle pulse when a request is rejected.
- lcd_load  out  1  one-cycle pulse: send one byte to the serializer.
- lcd_load16  out  1  one-cycle pulse: send one 16-bit data word.
- lcd_in  out  16  serializer data bus.
- lcd_busy  in  1  serializer busy flag, wired to its out[15].

## Operation
- Reset values:
  - state=IDLE
  - busy=0, done=0, err=0
  - lcd_load=0, lcd_load16=0, lcd_in=0
  - step, column and row counters cleared
- Request acceptance:
  - In IDLE, start=1 latches x0, x1, y0, y1 and color.
  - A request is rejected when x0>x1, y0>y1, x1>=WIDTH or y1>=HEIGHT. On rejection: err pulses on the next cycle, busy stays 0, and no transfer is issued.
  - start is ignored while busy=1.
- Byte encoding: lcd_in = {6'b0, dc, 1'b0, byte[7:0]}, where dc=0 for a command and dc=1 for a parameter byte.
- Transfer order (step 0..10), all via lcd_load:
  - 0x002A, then x0 high byte, x0 low byte, x1 high byte, x1 low byte.
  - 0x002B, then y0 high, y0 low, y1 high, y1 low.
  - 0x002C.
  - High byte = {7'b0, v[8]}; low byte = v[7:0].
- Pixel phase:
  - (x1-x0+1)*(y1-y0+1) lcd_load16 pulses, each with lcd_in=color.
  - Counted by nested column and row counters; no multiplier.
- States:
  - IDLE: on an accepted start, go to SEND.
  - SEND: wait until lcd_busy=0, then pulse lcd_load or lcd_load16 with lcd_in valid, and go to GUARD.
  - GUARD: one cycle, to cover the serializer's registered busy rise.
  - WAIT: stay until lcd_busy=0, then go to NEXT.
  - NEXT: advance the step or pixel counters. Go to SEND, or, after the last pixel, go to IDLE with done=1 and busy=0.
- Only one of lcd_load and lcd_load16 is ever high, and each is high for exactly one cycle per transfer.
- Reset mid-operation: the block returns to IDLE immediately and pulses nothing further. A transfer already inside the serializer completes on its own. The next request's first SEND waits for lcd_busy=0.

## Timing
- Start accepted at cycle N: busy=1 from N+1; the first lcd_load is at N+1 when lcd_busy=0.
- Transfer issued at cycle t:
  - GUARD at t+1.
  - WAIT from t+2 until lcd_busy is sampled low at cycle w.
  - NEXT at w+1.
  - Next pulse at w+2 at the earliest.
- done pulses, and busy falls, in the NEXT cycle after the last pixel's WAIT completes.
- err pulses at N+1 for a rejected request.
- lcd_in is stable from the pulse cycle until the next pulse.

## Structure
- Shared package lcd_pkg holds:
  - command constants CMD_CASET=8'h2A, CMD_PASET=8'h2B, CMD_RAMWR=8'h2C
  - the state enum
  - the dc bit index (9)
- One sub-module: lcd_xfer_handshake. It implements the SEND/GUARD/WAIT pacing, taking a request and returning xfer_done. The CASET/PASET sequencing, step counter and pixel counters stay in lcd_rect_fill.

## Test plan
- 1x1 fill, x=16, y=5, color=16'hF800, with a serializer model:
  - lcd_in sequence 002A, 0200, 0210, 0200, 0210, 002B, 0200, 0205, 0200, 0205, 002C, then one load16 of F800.
  - Exactly one done pulse; busy spans the whole sequence.
- Full screen x=0..239, y=0..319: parameter bytes 0200, 0200, 0200, 02EF and 0200, 0200, 0201, 023F; exactly 76800 load16 pulses, then done.
- x0=10, x1=9: err at N+1, no lcd_load, busy stays 0. Likewise y1=320.
- lcd_busy held high for 50 cycles at start: the first lcd_load is delayed until the cycle after lcd_busy drops.
- A second start while busy is ignored; the transfer count is unchanged.
- reset asserted during the pixel phase: all outputs at reset values the next cycle. A new start then waits for lcd_busy=0 and replays the sequence from 0x002A.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared constants, state encoding and byte-word packing for the LCD rectangle filler.
package lcd_pkg;

  localparam logic [7:0] CMD_CASET = 8'h2A;
  localparam logic [7:0] CMD_PASET = 8'h2B;
  localparam logic [7:0] CMD_RAMWR = 8'h2C;

  // Position of the data/command flag inside the serializer word.
  localparam int DC_BIT = 9;

  // Step 10 is the memory-write command; from step 11 on only pixels are sent.
  localparam logic [3:0] STEP_RAMWR = 4'd10;
  localparam logic [3:0] STEP_PIX   = 4'd11;

  typedef enum logic [2:0] {IDLE, SEND, GUARD, WAIT, NEXT} state_t;

  // Pack one byte with its dc flag into the serializer word layout.
  function automatic logic [15:0] lcd_word(input logic dc, input logic [7:0] b);
    logic [15:0] w;
    w         = {8'h00, b};
    w[DC_BIT] = dc;
    return w;
  endfunction

endpackage

// File: rtl/lcd_xfer_handshake.sv
// Paces one serializer transfer: wait for idle, pulse, guard the registered busy rise, wait for completion.
module lcd_xfer_handshake
  import lcd_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic req,
  input  logic req16,
  input  logic lcd_busy,
  output logic lcd_load,
  output logic lcd_load16,
  output logic xfer_done
);

  state_t state, state_nxt;
  logic   is16;

  // State register plus the latched transfer kind.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      is16  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && req) is16 <= req16;
    end
  end

  // Next state and the single-cycle load pulses.
  always_comb begin
    state_nxt  = state;
    lcd_load   = 1'b0;
    lcd_load16 = 1'b0;
    xfer_done  = 1'b0;
    case (state)
      IDLE:  if (req) state_nxt = SEND;
      SEND:  if (!lcd_busy) begin
               lcd_load   = !is16;
               lcd_load16 = is16;
               state_nxt  = GUARD;
             end
      GUARD: state_nxt = WAIT;
      WAIT:  if (!lcd_busy) begin
               xfer_done = 1'b1;
               state_nxt = IDLE;
             end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: rtl/lcd_rect_fill.sv
// Fills a panel rectangle with one colour: CASET/PASET/RAMWR with parameters, then one word per pixel.
module lcd_rect_fill
  import lcd_pkg::*;
#(
  parameter int WIDTH  = 240,
  parameter int HEIGHT = 320
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [8:0]  x0,
  input  logic [8:0]  x1,
  input  logic [8:0]  y0,
  input  logic [8:0]  y1,
  input  logic [15:0] color,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        lcd_load,
  output logic        lcd_load16,
  output logic [15:0] lcd_in,
  input  logic        lcd_busy
);

  localparam logic [9:0] X_LIM = 10'(WIDTH);
  localparam logic [9:0] Y_LIM = 10'(HEIGHT);

  state_t      state, state_nxt;
  logic [3:0]  step;
  logic [8:0]  xs, xe, ys, ye, col, row;
  logic [15:0] pix;
  logic        err_q, req, req16, xfer_done, req_ok, last;

  assign req_ok = (x0 <= x1) && (y0 <= y1) && ({1'b0, x1} < X_LIM) && ({1'b0, y1} < Y_LIM);
  assign last   = (step == STEP_PIX) && (col == xe) && (row == ye);
  assign err    = err_q;

  // Serializer word for a given step of the command preamble; pixel steps carry the colour.
  function automatic logic [15:0] word_at(input logic [3:0] s);
    case (s)
      4'd0:    return lcd_word(1'b0, CMD_CASET);
      4'd1:    return lcd_word(1'b1, {7'b0, xs[8]});
      4'd2:    return lcd_word(1'b1, xs[7:0]);
      4'd3:    return lcd_word(1'b1, {7'b0, xe[8]});
      4'd4:    return lcd_word(1'b1, xe[7:0]);
      4'd5:    return lcd_word(1'b0, CMD_PASET);
      4'd6:    return lcd_word(1'b1, {7'b0, ys[8]});
      4'd7:    return lcd_word(1'b1, ys[7:0]);
      4'd8:    return lcd_word(1'b1, {7'b0, ye[8]});
      4'd9:    return lcd_word(1'b1, ye[7:0]);
      4'd10:   return lcd_word(1'b0, CMD_RAMWR);
      default: return pix;
    endcase
  endfunction

  lcd_xfer_handshake u_hs (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .req16      (req16),
    .lcd_busy   (lcd_busy),
    .lcd_load   (lcd_load),
    .lcd_load16 (lcd_load16),
    .xfer_done  (xfer_done)
  );

  // Sequencer state register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Sequencer next state, transfer requests and status outputs.
  always_comb begin
    state_nxt = state;
    req       = 1'b0;
    req16     = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: if (start && req_ok) begin
              state_nxt = SEND;
              req       = 1'b1;
            end
      SEND: begin
              busy = 1'b1;
              if (xfer_done) state_nxt = NEXT;
            end
      NEXT: if (last) begin
              done      = 1'b1;
              state_nxt = IDLE;
            end else begin
              busy      = 1'b1;
              req       = 1'b1;
              req16     = (step >= STEP_RAMWR);
              state_nxt = SEND;
            end
      default: state_nxt = IDLE;
    endcase
  end

  // Request latch, step/pixel counters, outgoing word and the reject flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_q  <= 1'b0;
      step   <= '0;
      xs     <= '0;
      xe     <= '0;
      ys     <= '0;
      ye     <= '0;
      col    <= '0;
      row    <= '0;
      pix    <= '0;
      lcd_in <= '0;
    end else begin
      err_q <= (state == IDLE) && start && !req_ok;
      if (state == IDLE && start && req_ok) begin
        xs     <= x0;
        xe     <= x1;
        ys     <= y0;
        ye     <= y1;
        pix    <= color;
        col    <= x0;
        row    <= y0;
        step   <= '0;
        lcd_in <= lcd_word(1'b0, CMD_CASET);
      end else if (state == NEXT && !last) begin
        if (step != STEP_PIX) begin
          step   <= step + 4'd1;
          lcd_in <= word_at(step + 4'd1);
        end else if (col == xe) begin
          col <= xs;
          row <= row + 9'd1;
        end else begin
          col <= col + 9'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_lcd_rect_fill.sv
// Randomized bench for lcd_rect_fill with a behavioural serializer and expected-transfer model.
module tb_lcd_rect_fill;

  logic        clk = 1'b0;
  logic        reset, start, start_s;
  logic [8:0]  x0, x1, y0, y1;
  logic [15:0] color;
  logic        busy, done, err, lcd_load, lcd_load16;
  logic [15:0] lcd_in;
  logic        lcd_busy = 1'b0;
  logic        busy_s, done_s, err_s, load_s, load16_s;
  logic [15:0] in_s;
  logic        lcd_busy_s = 1'b0;

  int vec = 0, bad = 0, cyc = 0;

  always #20 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  lcd_rect_fill dut (
    .clk(clk), .reset(reset), .start(start), .x0(x0), .x1(x1), .y0(y0), .y1(y1),
    .color(color), .busy(busy), .done(done), .err(err), .lcd_load(lcd_load),
    .lcd_load16(lcd_load16), .lcd_in(lcd_in), .lcd_busy(lcd_busy)
  );

  // Small panel so a whole-screen fill can run to completion.
  lcd_rect_fill #(.WIDTH(12), .HEIGHT(10)) dut_s (
    .clk(clk), .reset(reset), .start(start_s), .x0(x0), .x1(x1), .y0(y0), .y1(y1),
    .color(color), .busy(busy_s), .done(done_s), .err(err_s), .lcd_load(load_s),
    .lcd_load16(load16_s), .lcd_in(in_s), .lcd_busy(lcd_busy_s)
  );

  // Serializer model: busy rises the cycle after a load and stays 1..3 cycles.
  logic pend = 1'b0, pend_s = 1'b0, force_busy = 1'b0;
  int   scnt = 0;
  always @(negedge clk) begin
    pend   = lcd_load | lcd_load16;
    pend_s = load_s | load16_s;
  end
  always @(posedge clk) begin
    int n;
    n = pend ? int'($urandom_range(1, 3)) : (scnt > 0 ? scnt - 1 : 0);
    scnt       <= n;
    lcd_busy   <= force_busy || (n != 0);
    lcd_busy_s <= pend_s;
  end

  // Transfer monitor: every load recorded as {is_pixel, word}.
  logic [16:0] q[$], qs[$], exp_q[$];
  int n_ld = 0, n_ld16 = 0, n_done = 0, n_both = 0, n_done_s = 0;
  always @(negedge clk) begin
    if (lcd_load && lcd_load16) n_both++;
    if (lcd_load)   begin q.push_back({1'b0, lcd_in}); n_ld++;   end
    if (lcd_load16) begin q.push_back({1'b1, lcd_in}); n_ld16++; end
    if (done) n_done++;
    if (load_s)   qs.push_back({1'b0, in_s});
    if (load16_s) qs.push_back({1'b1, in_s});
    if (done_s) n_done_s++;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  function automatic logic [16:0] pbyte(input logic [8:0] v, input bit hi);
    return {1'b0, 16'h0200 + (hi ? 16'(v / 256) : 16'(v % 256))};
  endfunction

  // Reference: the command preamble then one pixel word per rectangle pixel.
  task automatic make_exp(input logic [8:0] a, b, c, d, input logic [15:0] colr);
    int npix;
    exp_q.delete();
    exp_q.push_back(17'h0002A);
    exp_q.push_back(pbyte(a, 1)); exp_q.push_back(pbyte(a, 0));
    exp_q.push_back(pbyte(b, 1)); exp_q.push_back(pbyte(b, 0));
    exp_q.push_back(17'h0002B);
    exp_q.push_back(pbyte(c, 1)); exp_q.push_back(pbyte(c, 0));
    exp_q.push_back(pbyte(d, 1)); exp_q.push_back(pbyte(d, 0));
    exp_q.push_back(17'h0002C);
    npix = (int'(b) - int'(a) + 1) * (int'(d) - int'(c) + 1);
    for (int i = 0; i < npix; i++) exp_q.push_back({1'b1, colr});
  endtask

  task automatic set_rect(input logic [8:0] a, b, c, d, input logic [15:0] colr);
    x0 = a; x1 = b; y0 = c; y1 = d; color = colr;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; start_s = 1'b0;
    set_rect(0, 0, 0, 0, 0);
    repeat (3) tick();
    vec++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got %b want 0", busy); end
    vec++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got %b want 0", done); end
    vec++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err got %b want 0", err); end
    vec++; if ({lcd_load, lcd_load16} !== 2'b00) begin bad++; $display("FAIL reset_loads got %b want 00", {lcd_load, lcd_load16}); end
    vec++; if (lcd_in !== 16'h0) begin bad++; $display("FAIL reset_lcd_in got %h want 0000", lcd_in); end
    reset = 1'b0;
    repeat (4) tick();
  endtask

  // Runs one rectangle to done; optionally fires a second start mid-run.
  task automatic do_rect(input string nm, input logic [8:0] a, b, c, d,
                         input logic [15:0] colr, input bit inject, output int qb);
    int  d0, nb;
    bit  got, span_ok;
    make_exp(a, b, c, d, colr);
    qb = q.size(); d0 = n_done;
    set_rect(a, b, c, d, colr);
    start = 1'b1; tick(); start = 1'b0;
    got = 0; span_ok = 1;
    for (int t = 0; t < 20000 && !got; t++) begin
      if (done) begin got = 1; if (busy) span_ok = 0; end
      else if (!busy) span_ok = 0;
      if (!got) begin
        if (inject && t == 3) begin set_rect(0, 1, 0, 1, 16'h1234); start = 1'b1; end
        tick();
        start = 1'b0;
      end
    end
    vec++; if (!got) begin bad++; $display("FAIL %s_timeout got no done want done", nm); end
    vec++; if (!span_ok) begin bad++; $display("FAIL %s_busy_span got gap want busy until done", nm); end
    tick(); tick();
    vec++; if (n_done - d0 !== 1) begin bad++; $display("FAIL %s_done_count got %0d want 1", nm, n_done - d0); end
    nb = 0;
    if (q.size() - qb != exp_q.size()) nb++;
    else for (int i = 0; i < exp_q.size(); i++) if (q[qb + i] !== exp_q[i]) nb++;
    vec++; if (nb != 0) begin bad++; $display("FAIL %s_sequence got %0d words/%0d bad want %0d words", nm, q.size() - qb, nb, exp_q.size()); end
  endtask

  task automatic test_1x1();
    logic [16:0] lit[12] = '{17'h0002A, 17'h00200, 17'h00210, 17'h00200, 17'h00210, 17'h0002B,
                             17'h00200, 17'h00205, 17'h00200, 17'h00205, 17'h0002C, 17'h1F800};
    int qb, nb;
    do_rect("one_px", 9'd16, 9'd16, 9'd5, 9'd5, 16'hF800, 0, qb);
    nb = 0;
    for (int i = 0; i < 12; i++) if (q.size() <= qb + i || q[qb + i] !== lit[i]) nb++;
    vec++; if (nb != 0) begin bad++; $display("FAIL one_px_literal got %0d bad words want 0", nb); end
  endtask

  task automatic test_random();
    int qb;
    logic [8:0] a, c;
    for (int k = 0; k < 6; k++) begin
      a = 9'($urandom_range(0, 230)); c = 9'($urandom_range(0, 310));
      do_rect("rand", a, a + 9'($urandom_range(0, 5)), c, c + 9'($urandom_range(0, 5)),
              16'($urandom), 0, qb);
    end
  endtask

  task automatic test_reject(input string nm, input logic [8:0] a, b, c, d);
    int l0;
    l0 = n_ld + n_ld16;
    set_rect(a, b, c, d, 16'hABCD);
    start = 1'b1; tick(); start = 1'b0;
    vec++; if (err !== 1'b1) begin bad++; $display("FAIL %s_err got %b want 1", nm, err); end
    vec++; if (busy !== 1'b0) begin bad++; $display("FAIL %s_busy got %b want 0", nm, busy); end
    tick();
    vec++; if (err !== 1'b0) begin bad++; $display("FAIL %s_err_pulse got %b want 0", nm, err); end
    repeat (4) tick();
    vec++; if (n_ld + n_ld16 != l0) begin bad++; $display("FAIL %s_no_load got %0d want 0", nm, n_ld + n_ld16 - l0); end
  endtask

  // Holds serializer busy across the start; the first load must wait for its fall.
  task automatic busy_hold_rect(input string nm, input int hold);
    int ld0, qb, d0, nb;
    bit seen, got;
    logic [8:0] a, c;
    logic [15:0] colr;
    force_busy = 1'b1; tick(); tick();
    a = 9'($urandom_range(0, 200)); c = 9'($urandom_range(0, 300)); colr = 16'($urandom);
    make_exp(a, a + 9'd1, c, c, colr);
    ld0 = n_ld; qb = q.size(); d0 = n_done;
    set_rect(a, a + 9'd1, c, c, colr);
    start = 1'b1; tick(); start = 1'b0;
    repeat (hold - 1) tick();
    vec++; if (n_ld != ld0) begin bad++; $display("FAIL %s_early_load got %0d want 0", nm, n_ld - ld0); end
    force_busy = 1'b0;
    seen = 0;
    for (int t = 0; t < 10 && !seen; t++) begin tick(); if (!lcd_busy) seen = 1; end
    vec++;
    if (!seen || lcd_load !== 1'b1 || lcd_in !== 16'h002A || n_ld != ld0 + 1) begin
      bad++; $display("FAIL %s_first_load got load=%b in=%h n=%0d want load=1 in=002a n=1", nm, lcd_load, lcd_in, n_ld - ld0);
    end
    got = 0;
    for (int t = 0; t < 5000 && !got; t++) begin tick(); if (n_done > d0) got = 1; end
    tick(); tick();
    nb = 0;
    if (q.size() - qb != exp_q.size()) nb++;
    else for (int i = 0; i < exp_q.size(); i++) if (q[qb + i] !== exp_q[i]) nb++;
    vec++; if (!got || nb != 0) begin bad++; $display("FAIL %s_sequence got done=%b bad=%0d want done=1 bad=0", nm, got, nb); end
  endtask

  // Full-screen parameters, then reset in the pixel phase and replay.
  task automatic test_fullscreen_reset();
    int qb, nb;
    bit got;
    logic [15:0] colr;
    colr = 16'($urandom);
    make_exp(0, 239, 0, 319, colr);
    qb = q.size();
    set_rect(0, 239, 0, 319, colr);
    start = 1'b1; tick(); start = 1'b0;
    got = 0;
    for (int t = 0; t < 3000 && !got; t++) begin tick(); if (q.size() - qb >= 31) got = 1; end
    nb = 0;
    for (int i = 0; i < 31; i++) if (q.size() <= qb + i || q[qb + i] !== exp_q[i]) nb++;
    vec++; if (!got || nb != 0) begin bad++; $display("FAIL full_params got %0d bad words want 0", nb); end
    reset = 1'b1; tick();
    vec++;
    if ({busy, done, err, lcd_load, lcd_load16} !== 5'b0 || lcd_in !== 16'h0) begin
      bad++; $display("FAIL mid_reset got flags=%b in=%h want 00000/0000", {busy, done, err, lcd_load, lcd_load16}, lcd_in);
    end
    reset = 1'b0;
    busy_hold_rect("replay", 5);
  endtask

  task automatic test_back_to_back_ignore();
    int qb;
    do_rect("ignore", 9'd100, 9'd102, 9'd200, 9'd202, 16'h07E0, 1, qb);
  endtask

  task automatic test_small_full();
    int qb, d0, nb;
    bit got;
    make_exp(0, 11, 0, 9, 16'h001F);
    qb = qs.size(); d0 = n_done_s;
    set_rect(0, 11, 0, 9, 16'h001F);
    start_s = 1'b1; tick(); start_s = 1'b0;
    got = 0;
    for (int t = 0; t < 5000 && !got; t++) begin tick(); if (n_done_s > d0) got = 1; end
    tick(); tick();
    vec++; if (!got || n_done_s - d0 != 1) begin bad++; $display("FAIL small_done got %0d want 1", n_done_s - d0); end
    nb = 0;
    if (qs.size() - qb != exp_q.size()) nb++;
    else for (int i = 0; i < exp_q.size(); i++) if (qs[qb + i] !== exp_q[i]) nb++;
    vec++; if (nb != 0) begin bad++; $display("FAIL small_sequence got %0d words/%0d bad want %0d", qs.size() - qb, nb, exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_1x1();
    test_random();
    test_reject("x_order", 9'd10, 9'd9, 9'd0, 9'd0);
    test_reject("y_range", 9'd0, 9'd0, 9'd0, 9'd320);
    busy_hold_rect("busy_hold", 50);
    test_back_to_back_ignore();
    test_fullscreen_reset();
    test_small_full();
    vec++; if (n_both != 0) begin bad++; $display("FAIL both_loads got %0d want 0", n_both); end
    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end

endmodule
